// File: rtl/adc_multi_rx_if.sv
// AXI-Stream style sample output bundle for adc_multi_rx.
`timescale 1ns/1ps
interface adc_multi_rx_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic [2:0]  tuser;
  logic        tlast;

  modport master (output tdata, tvalid, tuser, tlast, input tready);
  modport slave  (input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/adc_multi_rx.sv
// Multi-lane serial ADC frame receiver: shared SCO/FSO, NUM_CH SDO lanes,
// frame FIFO and per-channel stream output.
// state | meaning
// IDLE  | waiting for a bit event with frame sync low
// SHIFT | collecting 32 frame bits on every lane
// PUSH  | writing the frame to the FIFO, or dropping it when full
`timescale 1ns/1ps
module adc_multi_rx #(
  parameter int NUM_CH     = 4,
  parameter int SAMPLE_W   = 24,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              adc_sco,
  input  logic              adc_fson,
  input  logic [NUM_CH-1:0] adc_sdo,
  input  logic              cfg_enable,
  input  logic              cfg_status_en,
  input  logic              cfg_clear,
  adc_multi_rx_if.master    m_axis,
  output logic [31:0]       frame_count,
  output logic [15:0]       overflow_count,
  output logic [15:0]       frame_err_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PUSH} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_sco_m, r_sco_s, r_sco_q, r_fson_m, r_fson_s;
  logic [NUM_CH-1:0] r_sdo_m, r_sdo_s;
  logic [4:0]        r_bit_cnt;
  logic [30:0]       r_sr [NUM_CH];
  logic [31:0]       r_mem [FIFO_DEPTH][NUM_CH];
  logic [AW:0]       r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]     r_ch;
  logic [31:0]       r_frame_cnt;
  logic [15:0]       r_ovf_cnt, r_err_cnt;

  logic              w_bit_ev, w_start, w_shift, w_abort, w_push;
  logic              w_empty, w_full, w_wr, w_ovf, w_valid, w_hs, w_last;
  logic [SAMPLE_W-1:0] w_smp [NUM_CH];
  logic [6:0]        w_st   [NUM_CH];
  logic [23:0]       w_lj   [NUM_CH];
  logic [31:0]       w_pack [NUM_CH];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_sco_m  <= 1'b0;
      r_sco_s  <= 1'b0;
      r_sco_q  <= 1'b0;
      r_fson_m <= 1'b0;
      r_fson_s <= 1'b0;
      r_sdo_m  <= '0;
      r_sdo_s  <= '0;
    end else begin
      r_sco_m  <= adc_sco;
      r_sco_s  <= r_sco_m;
      r_sco_q  <= r_sco_s;
      r_fson_m <= adc_fson;
      r_fson_s <= r_fson_m;
      r_sdo_m  <= adc_sdo;
      r_sdo_s  <= r_sdo_m;
    end
  end

  assign w_bit_ev = r_sco_s & ~r_sco_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_shift     = 1'b0;
    w_abort     = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_bit_ev && !r_fson_s && cfg_enable) begin
          w_start     = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_bit_ev) begin
          if (!r_fson_s) begin
            w_abort = 1'b1;
          end else begin
            w_shift = 1'b1;
            if (r_bit_cnt == 5'd31) w_state_nxt = S_PUSH;
          end
        end
      end
      S_PUSH: begin
        w_push      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)                r_bit_cnt <= '0;
    else if (w_start || w_abort) r_bit_cnt <= '0;
    else if (w_shift)            r_bit_cnt <= r_bit_cnt + 5'd1;
  end

  // The 32nd frame bit is never stored, so the register only holds 31 bits.
  always_ff @(posedge aclk) begin
    if (w_shift && r_bit_cnt != 5'd31) begin
      for (int c = 0; c < NUM_CH; c++) r_sr[c] <= {r_sr[c][29:0], r_sdo_s[c]};
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign w_smp[g]  = r_sr[g][30 -: SAMPLE_W];
    assign w_st[g]   = r_sr[g][30-SAMPLE_W -: 7];
    assign w_lj[g]   = 24'(w_smp[g]) << (24 - SAMPLE_W);
    assign w_pack[g] = cfg_status_en ? {w_lj[g], w_st[g], 1'b0} : 32'($signed(w_smp[g]));
  end

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_wr    = w_push && !w_full;
  assign w_ovf   = w_push && w_full;
  assign w_valid = !w_empty;
  assign w_last  = (r_ch == CW'(NUM_CH - 1));
  assign w_hs    = w_valid && m_axis.tready;

  always_ff @(posedge aclk) begin
    if (w_wr) begin
      for (int c = 0; c < NUM_CH; c++) r_mem[r_wr_ptr[AW-1:0]][c] <= w_pack[c];
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ch     <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_hs) begin
        if (w_last) begin
          r_ch     <= '0;
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end else begin
          r_ch <= r_ch + 1'b1;
        end
      end
    end
  end

  // Outputs come only from registers, so tready never reaches tvalid.
  assign m_axis.tvalid = w_valid;
  assign m_axis.tdata  = w_valid ? r_mem[r_rd_ptr[AW-1:0]][r_ch] : 32'd0;
  assign m_axis.tuser  = 3'(r_ch);
  assign m_axis.tlast  = w_valid && w_last;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_frame_cnt <= '0;
      r_ovf_cnt   <= '0;
      r_err_cnt   <= '0;
    end else if (cfg_clear) begin
      r_frame_cnt <= '0;
      r_ovf_cnt   <= '0;
      r_err_cnt   <= '0;
    end else begin
      if (w_wr) r_frame_cnt <= r_frame_cnt + 32'd1;
      if (w_ovf && r_ovf_cnt != 16'hFFFF) r_ovf_cnt <= r_ovf_cnt + 16'd1;
      if (w_abort && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign frame_count     = r_frame_cnt;
  assign overflow_count  = r_ovf_cnt;
  assign frame_err_count = r_err_cnt;
endmodule

// File: tb/tb_adc_multi_rx.sv
// Self-checking bench for adc_multi_rx: table vectors, directed corner cases,
// and random frames scored against a frame-level reference model.
`timescale 1ns/1ps
module tb_adc_multi_rx;
  localparam int NCH = 4;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic adc_sco = 1'b0;
  logic adc_fson = 1'b1;
  logic [NCH-1:0] adc_sdo = '0;
  logic cfg_enable = 1'b0;
  logic cfg_status_en = 1'b0;
  logic cfg_clear = 1'b0;
  logic [31:0] frame_count;
  logic [15:0] overflow_count, frame_err_count;

  adc_multi_rx_if axis ();

  adc_multi_rx #(.NUM_CH(NCH), .SAMPLE_W(24), .FIFO_DEPTH(16)) dut (
    .aclk(aclk), .aresetn(aresetn), .adc_sco(adc_sco), .adc_fson(adc_fson),
    .adc_sdo(adc_sdo), .cfg_enable(cfg_enable), .cfg_status_en(cfg_status_en),
    .cfg_clear(cfg_clear), .m_axis(axis), .frame_count(frame_count),
    .overflow_count(overflow_count), .frame_err_count(frame_err_count)
  );

  always #5 aclk = ~aclk;

  int n_chk = 0;
  int n_fail = 0;
  int n_beats = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  user;
  } beat_t;
  beat_t exp_q[$];

  // Frame-level packing model, written as plain arithmetic on the sample value.
  function automatic logic [31:0] ref_pack(input logic [23:0] s, input logic [6:0] st, input logic en);
    logic [31:0] v;
    v = {8'd0, s};
    if (en) return v * 256 + {25'd0, st} * 2;
    return (v >= 32'h0080_0000) ? v + 32'hFF00_0000 : v;
  endfunction

  // tready driver: 0 = fixed level, 1 = toggle each cycle, 2 = random
  int rdy_mode = 0;
  logic rdy_fix = 1'b1;
  initial begin
    axis.tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      case (rdy_mode)
        0:       axis.tready = rdy_fix;
        1:       axis.tready = ~axis.tready;
        default: axis.tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  logic        stall_prev = 1'b0;
  logic [31:0] prev_data;
  logic [2:0]  prev_user;
  logic        prev_last;
  beat_t       mon_e;
  always @(negedge aclk) begin
    if (!aresetn) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", {31'd0, axis.tvalid}, 32'd1);
        chk("hold_data", axis.tdata, prev_data);
        chk("hold_user", {29'd0, axis.tuser}, {29'd0, prev_user});
        chk("hold_last", {31'd0, axis.tlast}, {31'd0, prev_last});
      end
      if (axis.tvalid && axis.tready) begin
        n_beats++;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_beat: got data %h user %0d, required no beat", axis.tdata, axis.tuser);
        end else begin
          mon_e = exp_q.pop_front();
          chk("beat_data", axis.tdata, mon_e.data);
          chk("beat_user", {29'd0, axis.tuser}, {29'd0, mon_e.user});
          chk("beat_last", {31'd0, axis.tlast}, {31'd0, (mon_e.user == 3'd3)});
        end
      end
      stall_prev = axis.tvalid && !axis.tready;
      prev_data  = axis.tdata;
      prev_user  = axis.tuser;
      prev_last  = axis.tlast;
    end
  end

  task automatic send_bit(input logic fs, input logic [NCH-1:0] d);
    adc_sco  = 1'b0;
    adc_fson = fs;
    adc_sdo  = d;
    #20;
    adc_sco  = 1'b1;
    #20;
  endtask

  task automatic idle_bit();
    send_bit(1'b1, '0);
  endtask

  // Frame sync bit followed by n_bits frame bits (MSB first, status, one ignored bit).
  task automatic send_body(input logic [NCH-1:0][23:0] smp, input logic [NCH-1:0][6:0] st,
                           input int n_bits, input int en_drop_at);
    logic [NCH-1:0] d;
    send_bit(1'b0, NCH'($urandom));
    for (int k = 0; k < n_bits; k++) begin
      for (int c = 0; c < NCH; c++) begin
        if (k < 24)      d[c] = smp[c][23-k];
        else if (k < 31) d[c] = st[c][30-k];
        else             d[c] = 1'($urandom);
      end
      if (k == en_drop_at) cfg_enable = 1'b0;
      send_bit(1'b1, d);
    end
  endtask

  task automatic expect_frame(input logic [NCH-1:0][23:0] smp, input logic [NCH-1:0][6:0] st);
    for (int c = 0; c < NCH; c++) exp_q.push_back('{data: ref_pack(smp[c], st[c], cfg_status_en), user: 3'(c)});
  endtask

  task automatic full_frame(input logic [NCH-1:0][23:0] smp, input logic [NCH-1:0][6:0] st, input logic accept);
    send_body(smp, st, 32, -1);
    if (accept) expect_frame(smp, st);
    idle_bit();
  endtask

  task automatic wait_drain(input string name, input int budget);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      @(negedge aclk);
      i++;
    end
    chk(name, exp_q.size(), 0);
    exp_q.delete();
    repeat (10) @(negedge aclk);
  endtask

  logic [NCH-1:0][23:0] r_smp;
  logic [NCH-1:0][6:0]  r_st;
  task automatic rand_frame();
    for (int c = 0; c < NCH; c++) begin
      r_smp[c] = 24'($urandom);
      r_st[c]  = 7'($urandom);
    end
  endtask

  typedef struct packed {
    logic [NCH-1:0][23:0] smp;
    logic [NCH-1:0][6:0]  st;
    logic                 en;
    logic [NCH-1:0][31:0] exp;
  } vec_t;
  vec_t vt[5];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  int base, beats0;
  initial begin
    // Packed arrays list channel 3 first.
    vt[0] = '{smp: {24'h000004, 24'h000003, 24'h000002, 24'h000001}, st: {7'h00, 7'h00, 7'h00, 7'h00},
              en: 1'b0, exp: {32'h00000004, 32'h00000003, 32'h00000002, 32'h00000001}};
    vt[1] = '{smp: {24'hFFFFFF, 24'h000000, 24'h7FFFFF, 24'h800000}, st: {7'h01, 7'h00, 7'h7F, 7'h55},
              en: 1'b1, exp: {32'hFFFFFF02, 32'h00000000, 32'h7FFFFFFE, 32'h800000AA}};
    vt[2] = '{smp: {24'hFFFFFF, 24'h000000, 24'h7FFFFF, 24'h800000}, st: {7'h01, 7'h00, 7'h7F, 7'h55},
              en: 1'b0, exp: {32'hFFFFFFFF, 32'h00000000, 32'h007FFFFF, 32'hFF800000}};
    vt[3] = '{smp: {24'hFEDCBA, 24'h000001, 24'hABCDEF, 24'h123456}, st: {7'h00, 7'h40, 7'h7F, 7'h2A},
              en: 1'b1, exp: {32'hFEDCBA00, 32'h00000180, 32'hABCDEFFE, 32'h12345654}};
    vt[4] = '{smp: {24'hFEDCBA, 24'h000001, 24'hABCDEF, 24'h123456}, st: {7'h00, 7'h40, 7'h7F, 7'h2A},
              en: 1'b0, exp: {32'hFFFEDCBA, 32'h00000001, 32'hFFABCDEF, 32'h00123456}};

    #20;
    chk("rst_tvalid", {31'd0, axis.tvalid}, 32'd0);
    chk("rst_tdata", axis.tdata, 32'd0);
    chk("rst_tuser", {29'd0, axis.tuser}, 32'd0);
    chk("rst_tlast", {31'd0, axis.tlast}, 32'd0);
    chk("rst_frame_count", frame_count, 32'd0);
    chk("rst_overflow_count", {16'd0, overflow_count}, 32'd0);
    chk("rst_frame_err_count", {16'd0, frame_err_count}, 32'd0);
    aresetn = 1'b1;
    cfg_enable = 1'b1;
    repeat (4) idle_bit();

    for (int i = 0; i < 5; i++) begin
      cfg_status_en = vt[i].en;
      send_body(vt[i].smp, vt[i].st, 32, -1);
      for (int c = 0; c < NCH; c++) exp_q.push_back('{data: vt[i].exp[c], user: 3'(c)});
      idle_bit();
      wait_drain("vec_drain", 500);
      chk("vec_frame_count", frame_count, 32'(i + 1));
    end

    // enable dropped mid-frame: frame still completes
    cfg_status_en = 1'b0;
    rand_frame();
    send_body(r_smp, r_st, 32, 5);
    expect_frame(r_smp, r_st);
    idle_bit();
    cfg_enable = 1'b1;
    wait_drain("en_drop_drain", 500);
    chk("en_drop_frame_count", frame_count, 32'd6);

    // disabled before frame sync: frame ignored
    cfg_enable = 1'b0;
    rand_frame();
    full_frame(r_smp, r_st, 1'b0);
    cfg_enable = 1'b1;
    wait_drain("disabled_drain", 100);
    chk("disabled_frame_count", frame_count, 32'd6);

    // frame sync low after bit 10 aborts; the abort bit starts the next frame
    rand_frame();
    send_body(r_smp, r_st, 10, -1);
    rand_frame();
    full_frame(r_smp, r_st, 1'b1);
    wait_drain("abort_drain", 500);
    chk("abort_err_count", {16'd0, frame_err_count}, 32'd1);
    chk("abort_frame_count", frame_count, 32'd7);

    // overflow: 20 frames into 16 entries while stalled
    rdy_mode = 0;
    rdy_fix = 1'b0;
    base = frame_count;
    cfg_status_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rand_frame();
      full_frame(r_smp, r_st, 1'(i < 16));
    end
    chk("ovf_overflow_count", {16'd0, overflow_count}, 32'd4);
    chk("ovf_frame_count", frame_count, 32'(base + 16));
    chk("ovf_tvalid", {31'd0, axis.tvalid}, 32'd1);
    beats0 = n_beats;
    rdy_fix = 1'b1;
    wait_drain("ovf_drain", 2000);
    chk("ovf_beats", 32'(n_beats - beats0), 32'd64);

    // tready toggling every cycle
    rdy_mode = 1;
    for (int i = 0; i < 4; i++) begin
      cfg_status_en = 1'($urandom);
      rand_frame();
      full_frame(r_smp, r_st, 1'b1);
    end
    wait_drain("toggle_drain", 1000);

    // random frames, random tready, random gaps
    rdy_mode = 2;
    base = frame_count;
    for (int i = 0; i < 12; i++) begin
      cfg_status_en = 1'($urandom);
      rand_frame();
      full_frame(r_smp, r_st, 1'b1);
      repeat ($urandom_range(0, 3)) idle_bit();
    end
    wait_drain("rand_drain", 1000);
    chk("rand_frame_count", frame_count, 32'(base + 12));

    // reset with a stored frame and a partial frame at bit 15
    rdy_mode = 0;
    rdy_fix = 1'b0;
    rand_frame();
    full_frame(r_smp, r_st, 1'b0);
    chk("pre_rst_tvalid", {31'd0, axis.tvalid}, 32'd1);
    rand_frame();
    send_body(r_smp, r_st, 15, -1);
    aresetn = 1'b0;
    #20;
    chk("mid_rst_tvalid", {31'd0, axis.tvalid}, 32'd0);
    chk("mid_rst_tdata", axis.tdata, 32'd0);
    chk("mid_rst_tuser", {29'd0, axis.tuser}, 32'd0);
    chk("mid_rst_tlast", {31'd0, axis.tlast}, 32'd0);
    chk("mid_rst_frame_count", frame_count, 32'd0);
    chk("mid_rst_overflow_count", {16'd0, overflow_count}, 32'd0);
    chk("mid_rst_err_count", {16'd0, frame_err_count}, 32'd0);
    aresetn = 1'b1;
    for (int k = 0; k < 17; k++) send_bit(1'b1, NCH'($urandom));
    idle_bit();
    rdy_fix = 1'b1;
    wait_drain("post_rst_partial", 100);
    chk("post_rst_frame_count", frame_count, 32'd0);
    rand_frame();
    full_frame(r_smp, r_st, 1'b1);
    wait_drain("post_rst_drain", 500);
    chk("post_rst_frame_count2", frame_count, 32'd1);

    // clear coincident with an overflow increment
    rdy_fix = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rand_frame();
      full_frame(r_smp, r_st, 1'b1);
    end
    rand_frame();
    full_frame(r_smp, r_st, 1'b0);
    chk("pre_clr_overflow_count", {16'd0, overflow_count}, 32'd1);
    rand_frame();
    send_body(r_smp, r_st, 32, -1);
    #11;
    cfg_clear = 1'b1;
    #6;
    cfg_clear = 1'b0;
    #3;
    idle_bit();
    chk("clr_overflow_count", {16'd0, overflow_count}, 32'd0);
    chk("clr_frame_count", frame_count, 32'd0);
    chk("clr_err_count", {16'd0, frame_err_count}, 32'd0);
    beats0 = n_beats;
    rdy_fix = 1'b1;
    wait_drain("clr_drain", 2000);
    chk("clr_beats", 32'(n_beats - beats0), 32'd64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
